tsb_bus_arbiter: RTL
====================

// Module: tsb_bus_arbiter
// PURPOSE
//  Upstream control stage for the shared tri-state bus built from TSB cells.
//  Arbitrates N requesters round-robin and drives one enable per TSB.
//  Guarantees break-before-make: at most one TSB en is high at any time.
//  Inserts DEAD all-low cycles between owners so two drivers never fight (no X on bus).
// PARAMETERS
//  N         4   number of requesters / TSB drivers (>=2)
//  DEAD      2   all-enables-low cycles between successive grants (>=1)
//  MAX_HOLD  8   max DRIVE cycles while others wait; 0 = unlimited hold
// PORTS
//  clk     in   1           single clock, rising edge
//  rst     in   1           synchronous, active-high reset
//  req     in   N           request vector, level-sensitive, bit i = requester i
//  en      out  N           one-hot-or-zero TSB enables, registered
//  gnt_id  out  clog2(N)    index of current/last owner, registered
//  busy    out  1           high whenever state != IDLE, registered
// BEHAVIOUR
//  Reset (rst sampled high at edge): en=0, gnt_id=0, busy=0, state=IDLE,
//    rr_ptr=0, hold_cnt=0, gap_cnt=0. Reset overrides everything, incl. mid-DRIVE.
//  Winner = first set req bit scanning rr_ptr, rr_ptr+1, ... mod N.
//  States:
//   IDLE : en=0. If |req at edge -> DRIVE; en=onehot(winner), gnt_id=winner,
//          hold_cnt=1 at the same edge (1-cycle req->en latency).
//   DRIVE: en holds onehot(owner); hold_cnt increments each cycle.
//          Release when req[owner]==0 sampled, OR (MAX_HOLD!=0 AND
//          hold_cnt==MAX_HOLD AND any other req bit set).
//          On release edge: en=0, rr_ptr=(owner+1) mod N, gap_cnt=DEAD, -> GAP.
//          Owner with req held and no contenders keeps bus indefinitely.
//   GAP  : en=0 for exactly DEAD cycles; gap_cnt decrements each edge.
//          At edge where gap_cnt==1: if |req -> DRIVE with new winner (no
//          IDLE cycle inserted), else -> IDLE. req sampled at that edge only.
//  gnt_id keeps last owner during GAP/IDLE; busy=1 in DRIVE and GAP.
//  Invariants (check every cycle): $onehot0(en); any en transition between
//    two different nonzero values passes through >=DEAD cycles of en==0;
//    en bit i high only if req[i] was high at the edge that set it.
//  Requester re-asserting during its own GAP is served only after scan from
//    rr_ptr, i.e. after all other pending requesters.
//  Width: hold_cnt sized clog2(MAX_HOLD+1), saturating when MAX_HOLD==0;
//    gap_cnt sized clog2(DEAD+1). rr_ptr wraps N-1 -> 0.
// TESTING (N=4, DEAD=2, MAX_HOLD=8)
//  1. rst high 2 cycles, req=4'b1010 -> en=0,gnt_id=0,busy=0; after rst low,
//     next edge en=4'b0010, gnt_id=1.
//  2. Single req=4'b0100 held 20 cycles -> en=4'b0100 whole time, no timeout
//     release; drop req -> en=0 for exactly 2 cycles then IDLE, busy=0.
//  3. req=4'b1111 held -> grant order 0,1,2,3,0; each owner 8 cycles DRIVE,
//     then 2 cycles en=0; $onehot0(en) never violated.
//  4. Owner 3 releases with req=4'b0001 -> rr_ptr wraps to 0, en=4'b0001
//     after 2-cycle gap (wrap-around).
//  5. req changes during GAP (4'b0010 -> 4'b1000 at gap_cnt==1 edge) ->
//     en=4'b1000; mid-GAP transient req ignored.
//  6. rst asserted mid-DRIVE with en=4'b0010 -> next edge en=0, rr_ptr=0;
//     after release with req=4'b0011, en=4'b0001.

Source files
------------

// File: rtl/tsb_bus_arbiter_if.sv
// Bus-side signal bundle for the TSB arbiter: requests in, enables and owner status out.
// The master modport is the arbiter; the slave modport is the requester/TSB side.
interface tsb_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int GW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic [GW-1:0] gnt_id;
    logic          busy;

    modport master (
        input  req,
        output en,
        output gnt_id,
        output busy
    );

    modport slave (
        output req,
        input  en,
        input  gnt_id,
        input  busy
    );
endinterface

// File: rtl/tsb_bus_arbiter.sv
// Round-robin arbiter driving one enable per tri-state bus cell.
// Break-before-make: every change of owner passes through DEAD all-low enable
// cycles so two drivers never fight on the shared bus.
module tsb_bus_arbiter #(
    parameter int N        = 4,
    parameter int DEAD     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    tsb_bus_arbiter_if.master  bus
);
    localparam int GW = $clog2(N);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int DW = $clog2(DEAD + 1);
    localparam logic [N-1:0] ONE_N = N'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [HW-1:0]   r_hold_cnt;
    logic [DW-1:0]   r_gap_cnt;
    logic [N-1:0]    r_en;
    logic [GW-1:0]   r_gnt_id;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_rr_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [DW-1:0]   w_gap_nxt;
    logic [GW-1:0]   w_gnt_nxt;
    logic [N-1:0]    w_en_nxt;
    logic            w_busy_nxt;

    logic [GW-1:0]   w_winner;
    int              w_scan_idx;
    logic            w_any_req;
    logic [N-1:0]    w_owner_oh;
    logic            w_others;
    logic            w_hold_at_max;
    logic            w_release;

    assign w_any_req  = |bus.req;
    assign w_owner_oh = ONE_N << r_gnt_id;
    assign w_others   = |(bus.req & ~w_owner_oh);

    // Hold counter saturates, so ">=" keeps the timeout armed for a contender
    // that shows up long after the owner passed MAX_HOLD.
    assign w_hold_at_max = (MAX_HOLD != 0) && (r_hold_cnt >= HW'(MAX_HOLD));
    assign w_release     = !bus.req[r_gnt_id] || (w_hold_at_max && w_others);

    // Winner: first requester found scanning upward from the round-robin pointer.
    always_comb begin
        w_winner   = r_rr_ptr;
        w_scan_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_scan_idx = (int'(r_rr_ptr) + k) % N;
            if (bus.req[w_scan_idx]) begin
                w_winner = GW'(w_scan_idx);
            end
        end
    end

    // State register plus registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_en       <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_en       <= w_en_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state logic: grant, hold/timeout release, dead-time countdown.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_gnt_nxt   = r_gnt_id;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_DRIVE;
                    w_gnt_nxt   = w_winner;
                    w_hold_nxt  = HW'(1);
                end
            end
            S_DRIVE: begin
                if (w_release) begin
                    w_state_nxt = S_GAP;
                    w_rr_nxt    = (r_gnt_id == GW'(N - 1)) ? '0 : r_gnt_id + GW'(1);
                    w_gap_nxt   = DW'(DEAD);
                end else if (r_hold_cnt != '1) begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            S_GAP: begin
                // req is only looked at on the final dead cycle; earlier
                // transients never reach the enables.
                if (r_gap_cnt <= DW'(1)) begin
                    if (w_any_req) begin
                        w_state_nxt = S_DRIVE;
                        w_gnt_nxt   = w_winner;
                        w_hold_nxt  = HW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so enables and busy are registered.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_en_nxt   = '0;
        if (w_state_nxt == S_DRIVE) begin
            w_en_nxt = ONE_N << w_gnt_nxt;
        end
    end

    assign bus.en     = r_en;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = r_busy;
endmodule
